// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder: loads a per-symbol {length, code} table,
// then matches the accumulated bit string against it one bit per enabled cycle.
module huffman_decoder #(
    parameter int unsigned BIT_WIDTH  = 2,
    parameter int unsigned SYMBOL_NUM = 8,
    parameter int unsigned CODE_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  table_enable,
    input  logic [BIT_WIDTH:0]    table_symbol,
    input  logic [3:0]            table_length,
    input  logic [CODE_WIDTH-1:0] table_code,
    input  logic                  table_done,
    input  logic                  table_clear,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [BIT_WIDTH:0]    data_out,
    output logic                  data_out_valid,
    output logic                  data_out_state,
    output logic                  error,
    output logic [7:0]            symbol_count
);

    localparam int unsigned SYM_W  = BIT_WIDTH + 1;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned MASK_W = CODE_WIDTH + 1;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_DECODE = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q  [SYMBOL_NUM];
    logic [LEN_W-1:0]      len_d  [SYMBOL_NUM];
    logic [CODE_WIDTH-1:0] code_q [SYMBOL_NUM];
    logic [CODE_WIDTH-1:0] code_d [SYMBOL_NUM];
    logic [CODE_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [SYM_W-1:0]      data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic [7:0]            count_q, count_d;

    logic [CODE_WIDTH-1:0] acc_n;
    logic [LEN_W-1:0]      cnt_n;
    logic [CODE_WIDTH-1:0] mask;
    logic                  hit;
    logic [SYM_W-1:0]      hit_sym;
    logic                  wr_ok;

    // Candidate accumulator after this bit and the lowest-index matching entry
    always_comb begin
        acc_n   = (acc_q << 1) | CODE_WIDTH'(bit_in);
        cnt_n   = cnt_q + LEN_W'(1);
        mask    = CODE_WIDTH'((MASK_W'(1) << cnt_n) - MASK_W'(1));
        hit     = 1'b0;
        hit_sym = '0;
        for (int unsigned i = 0; i < SYMBOL_NUM; i++) begin
            if (!hit && (len_q[i] != '0) && (len_q[i] == cnt_n) &&
                ((code_q[i] & mask) == (acc_n & mask))) begin
                hit     = 1'b1;
                hit_sym = SYM_W'(i);
            end
        end
        wr_ok = (32'(table_symbol) < SYMBOL_NUM) && (32'(table_length) <= CODE_WIDTH);
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        code_d     = code_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        count_d    = count_q;

        if (table_clear) begin
            for (int unsigned i = 0; i < SYMBOL_NUM; i++) begin
                len_d[i] = '0;
            end
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (table_enable) begin
                        if (wr_ok) begin
                            for (int unsigned i = 0; i < SYMBOL_NUM; i++) begin
                                if (table_symbol == SYM_W'(i)) begin
                                    len_d[i]  = table_length;
                                    code_d[i] = table_code;
                                end
                            end
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    if (table_done) begin
                        state_d = ST_DECODE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ST_DECODE: begin
                    if (bit_valid) begin
                        if (hit) begin
                            data_out_d = hit_sym;
                            valid_d    = 1'b1;
                            count_d    = count_q + 8'd1;
                            acc_d      = '0;
                            cnt_d      = '0;
                        end else if (32'(cnt_n) == CODE_WIDTH) begin
                            error_d = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            acc_d = acc_n;
                            cnt_d = cnt_n;
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOAD;
            acc_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            for (int unsigned i = 0; i < SYMBOL_NUM; i++) begin
                len_q[i]  <= '0;
                code_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            count_q    <= count_d;
            for (int unsigned i = 0; i < SYMBOL_NUM; i++) begin
                len_q[i]  <= len_d[i];
                code_q[i] <= code_d[i];
            end
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign data_out_state = (state_q == ST_DECODE);
    assign error          = error_q;
    assign symbol_count   = count_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: per-cycle vector tables plus hand-written
// load, reset and out-of-range sequences.
module tb_huffman_decoder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       table_enable, table_done, table_clear, bit_in, bit_valid;
    logic [2:0] table_symbol;
    logic [3:0] table_length;
    logic [7:0] table_code;
    logic [2:0] data_out;
    logic       data_out_valid, data_out_state, error;
    logic [7:0] symbol_count;

    // Second instance with fewer entries than the index port can address
    logic       b_table_enable, b_table_done, b_bit_in, b_bit_valid;
    logic [2:0] b_table_symbol;
    logic [3:0] b_table_length;
    logic [7:0] b_table_code;
    logic [2:0] b_data_out;
    logic       b_data_out_valid, b_data_out_state, b_error;
    logic [7:0] b_symbol_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic clr;
        logic bv;
        logic bi;
        logic ev;
        int   ed;
        logic ee;
        int   ecnt;
        logic est;
    } vec_t;

    vec_t vq[$];

    huffman_decoder #(.BIT_WIDTH(2), .SYMBOL_NUM(8), .CODE_WIDTH(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .table_enable(table_enable), .table_symbol(table_symbol),
        .table_length(table_length), .table_code(table_code),
        .table_done(table_done), .table_clear(table_clear),
        .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_state(data_out_state), .error(error),
        .symbol_count(symbol_count)
    );

    huffman_decoder #(.BIT_WIDTH(2), .SYMBOL_NUM(6), .CODE_WIDTH(8)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .table_enable(b_table_enable), .table_symbol(b_table_symbol),
        .table_length(b_table_length), .table_code(b_table_code),
        .table_done(b_table_done), .table_clear(1'b0),
        .bit_in(b_bit_in), .bit_valid(b_bit_valid),
        .data_out(b_data_out), .data_out_valid(b_data_out_valid),
        .data_out_state(b_data_out_state), .error(b_error),
        .symbol_count(b_symbol_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic clr, input logic bv, input logic bi, input logic ev,
                        input int ed, input logic ee, input int ecnt, input logic est);
        vec_t v;
        v.clr = clr; v.bv = bv; v.bi = bi; v.ev = ev;
        v.ed = ed; v.ee = ee; v.ecnt = ecnt; v.est = est;
        vq.push_back(v);
    endtask

    // Apply each queued vector for one cycle and check the registered outputs
    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            table_clear = vq[i].clr;
            bit_valid   = vq[i].bv;
            bit_in      = vq[i].bi;
            @(posedge clock);
            #1;
            chk($sformatf("%s[%0d] valid", tag, i), int'(data_out_valid), int'(vq[i].ev));
            chk($sformatf("%s[%0d] data", tag, i), int'(data_out), vq[i].ed);
            chk($sformatf("%s[%0d] error", tag, i), int'(error), int'(vq[i].ee));
            chk($sformatf("%s[%0d] count", tag, i), int'(symbol_count), vq[i].ecnt);
            chk($sformatf("%s[%0d] state", tag, i), int'(data_out_state), int'(vq[i].est));
        end
        vq.delete();
        table_clear = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
    endtask

    task automatic load_a(input int sym, input int len, input int code, input logic done,
                          input logic exp_err, input string nm);
        table_enable = 1'b1;
        table_symbol = 3'(sym);
        table_length = 4'(len);
        table_code   = 8'(code);
        table_done   = done;
        @(posedge clock);
        #1;
        table_enable = 1'b0;
        table_done   = 1'b0;
        chk({nm, " error"}, int'(error), int'(exp_err));
        chk({nm, " valid"}, int'(data_out_valid), 0);
    endtask

    task automatic load_b(input int sym, input int len, input int code, input logic done,
                          input logic exp_err, input string nm);
        b_table_enable = 1'b1;
        b_table_symbol = 3'(sym);
        b_table_length = 4'(len);
        b_table_code   = 8'(code);
        b_table_done   = done;
        @(posedge clock);
        #1;
        b_table_enable = 1'b0;
        b_table_done   = 1'b0;
        chk({nm, " error"}, int'(b_error), int'(exp_err));
    endtask

    initial begin
        reset_n = 1'b0;
        table_enable = 1'b0; table_done = 1'b0; table_clear = 1'b0;
        table_symbol = '0; table_length = '0; table_code = '0;
        bit_in = 1'b0; bit_valid = 1'b0;
        b_table_enable = 1'b0; b_table_done = 1'b0; b_bit_in = 1'b0; b_bit_valid = 1'b0;
        b_table_symbol = '0; b_table_length = '0; b_table_code = '0;
        #12;
        chk("reset data", int'(data_out), 0);
        chk("reset valid", int'(data_out_valid), 0);
        chk("reset error", int'(error), 0);
        chk("reset count", int'(symbol_count), 0);
        chk("reset state", int'(data_out_state), 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Prefix code table: 0 / 10 / 110 / 1110
        load_a(0, 1, 'b0,    1'b0, 1'b0, "load s0");
        load_a(1, 2, 'b10,   1'b0, 1'b0, "load s1");
        load_a(2, 3, 'b110,  1'b0, 1'b0, "load s2");
        load_a(3, 4, 'b1110, 1'b0, 1'b0, "load s3");
        table_done = 1'b1;
        @(posedge clock);
        #1;
        table_done = 1'b0;
        chk("done state", int'(data_out_state), 1);

        // Consecutive bits 0,1,0,1,1,0,1,1,1,0
        push(0, 1, 0, 1, 0, 0, 1, 1);
        push(0, 1, 1, 0, 0, 0, 1, 1);
        push(0, 1, 0, 1, 1, 0, 2, 1);
        push(0, 1, 1, 0, 1, 0, 2, 1);
        push(0, 1, 1, 0, 1, 0, 2, 1);
        push(0, 1, 0, 1, 2, 0, 3, 1);
        push(0, 1, 1, 0, 2, 0, 3, 1);
        push(0, 1, 1, 0, 2, 0, 3, 1);
        push(0, 1, 1, 0, 2, 0, 3, 1);
        push(0, 1, 0, 1, 3, 0, 4, 1);
        run_vecs("stream");

        // Gap inside a code
        push(0, 1, 1, 0, 3, 0, 4, 1);
        push(0, 0, 0, 0, 3, 0, 4, 1);
        push(0, 0, 1, 0, 3, 0, 4, 1);
        push(0, 0, 0, 0, 3, 0, 4, 1);
        push(0, 1, 0, 1, 1, 0, 5, 1);
        push(0, 0, 0, 0, 1, 0, 5, 1);
        run_vecs("gap");

        // Overrun after eight 1s, then recovery
        for (int i = 0; i < 7; i++) push(0, 1, 1, 0, 1, 0, 5, 1);
        push(0, 1, 1, 0, 1, 1, 5, 1);
        push(0, 1, 0, 1, 0, 0, 6, 1);
        run_vecs("overrun");

        // Clear mid-code, bits ignored in LOAD
        push(0, 1, 1, 0, 0, 0, 6, 1);
        push(0, 1, 1, 0, 0, 0, 6, 1);
        push(1, 1, 0, 0, 0, 0, 6, 0);
        push(0, 1, 0, 0, 0, 0, 6, 0);
        push(0, 1, 1, 0, 0, 0, 6, 0);
        run_vecs("clear");
        load_a(5, 1, 'b1, 1'b1, 1'b0, "load s5+done");
        chk("reload state", int'(data_out_state), 1);
        push(0, 1, 1, 1, 5, 0, 7, 1);
        run_vecs("reload");

        // Rejected write, max-length code, write+done in one cycle
        push(1, 0, 0, 0, 5, 0, 7, 0);
        run_vecs("clear2");
        load_a(0, 1, 'b0,  1'b0, 1'b0, "load s0");
        load_a(2, 8, 'hFF, 1'b0, 1'b0, "load s2 len8");
        load_a(0, 9, 'h01, 1'b0, 1'b1, "bad len9");
        load_a(1, 2, 'b10, 1'b1, 1'b0, "load s1+done");
        push(0, 1, 0, 1, 0, 0, 8, 1);
        push(0, 1, 1, 0, 0, 0, 8, 1);
        push(0, 1, 0, 1, 1, 0, 9, 1);
        for (int i = 0; i < 7; i++) push(0, 1, 1, 0, 1, 0, 9, 1);
        push(0, 1, 1, 1, 2, 0, 10, 1);
        run_vecs("maxlen");

        // Asynchronous reset mid-code
        push(0, 1, 1, 0, 2, 0, 10, 1);
        run_vecs("pre-reset");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async data", int'(data_out), 0);
        chk("async valid", int'(data_out_valid), 0);
        chk("async error", int'(error), 0);
        chk("async count", int'(symbol_count), 0);
        chk("async state", int'(data_out_state), 0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        table_done = 1'b1;
        @(posedge clock);
        #1;
        table_done = 1'b0;
        for (int i = 0; i < 7; i++) push(0, 1, 1, 0, 0, 0, 0, 1);
        push(0, 1, 0, 0, 0, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 0, 1);
        run_vecs("empty");

        // Out-of-range index on a six-entry table
        load_b(7, 1, 'b0, 1'b0, 1'b1, "b sym7");
        load_b(6, 1, 'b0, 1'b0, 1'b1, "b sym6");
        load_b(5, 1, 'b1, 1'b1, 1'b0, "b s5+done");
        b_bit_valid = 1'b1;
        b_bit_in    = 1'b1;
        @(posedge clock);
        #1;
        chk("b bit1 valid", int'(b_data_out_valid), 1);
        chk("b bit1 data", int'(b_data_out), 5);
        b_bit_in = 1'b0;
        @(posedge clock);
        #1;
        b_bit_valid = 1'b0;
        chk("b bit0 valid", int'(b_data_out_valid), 0);
        chk("b count", int'(b_symbol_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
